// File: rtl/seg7_digit_reader_if.sv
// seg7_digit_reader_if: TinyTapeout-style tile pins of the 7-segment reader.
// The master side drives the segment bus; the slave side is the reader.
interface seg7_digit_reader_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    modport master(output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
    modport slave(input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/seg7_digit_reader.sv
// seg7_digit_reader: samples a 7-segment bus, debounces it, decodes it to a hex
// nibble and keeps a 3-digit history with a one-cycle pulse per accepted digit.
module seg7_digit_reader #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input logic clk,
    input logic rst_n,
    seg7_digit_reader_if.slave io
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOCKED = 2'd1;
    localparam logic [1:0] SETTLE = 2'd2;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [7:0] sync1_q, sync2_q;
    logic [6:0] cand_q, cand_d, lock_q, lock_d, p;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0] state_q, state_d, count_q, count_d;
    logic [3:0] dig0_q, dig0_d, dig1_q, dig1_d, dig2_q, dig2_d;
    logic pulse_q, pulse_d, err_q, err_d, en, stable, act;
    logic [4:0] dec;
    logic unused_ok;

    // {valid, nibble}
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'h3F: decode = 5'h10;
            7'h06: decode = 5'h11;
            7'h5B: decode = 5'h12;
            7'h4F: decode = 5'h13;
            7'h66: decode = 5'h14;
            7'h6D: decode = 5'h15;
            7'h7D: decode = 5'h16;
            7'h07: decode = 5'h17;
            7'h7F: decode = 5'h18;
            7'h6F: decode = 5'h19;
            7'h77: decode = 5'h1A;
            7'h7C: decode = 5'h1B;
            7'h39: decode = 5'h1C;
            7'h5E: decode = 5'h1D;
            7'h79: decode = 5'h1E;
            7'h71: decode = 5'h1F;
            default: decode = 5'h00;
        endcase
    endfunction

    assign p      = sync2_q[6:0];
    assign en     = sync2_q[7];
    assign stable = (p == cand_q) && (cnt_q == CNT_MAX);
    assign dec    = decode(p);

    always_comb begin
        // Clearing the candidate while disabled makes a pattern already present at enable look new.
        cand_d  = en ? p : 7'h00;
        cnt_d   = (!en || p != cand_q) ? '0 : (cnt_q == CNT_MAX ? cnt_q : cnt_q + CNT_W'(1));
        state_d = state_q;
        act     = 1'b0;
        if (!en)
            state_d = IDLE;
        else if (state_q == LOCKED)
            state_d = (p != lock_q) ? SETTLE : LOCKED;
        else if (stable) begin
            if (p == 7'h00)
                state_d = IDLE;
            else if (state_q == SETTLE && p == lock_q)
                state_d = LOCKED;
            else begin
                act     = 1'b1;
                state_d = LOCKED;
            end
        end
        lock_d  = act ? p : lock_q;
        pulse_d = act && dec[4];
        err_d   = err_q | (act && !dec[4]);
        dig0_d  = pulse_d ? dec[3:0] : dig0_q;
        dig1_d  = pulse_d ? dig0_q : dig1_q;
        dig2_d  = pulse_d ? dig1_q : dig2_q;
        count_d = count_q + {1'b0, pulse_d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            cand_q  <= '0;
            lock_q  <= '0;
            cnt_q   <= '0;
            state_q <= IDLE;
            count_q <= '0;
            dig0_q  <= '0;
            dig1_q  <= '0;
            dig2_q  <= '0;
            pulse_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sync1_q <= io.ui_in;
            sync2_q <= sync1_q;
            cand_q  <= cand_d;
            lock_q  <= lock_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            count_q <= count_d;
            dig0_q  <= dig0_d;
            dig1_q  <= dig1_d;
            dig2_q  <= dig2_d;
            pulse_q <= pulse_d;
            err_q   <= err_d;
        end
    end

    assign io.uo_out  = {count_q, err_q, pulse_q, dig0_q};
    assign io.uio_out = {dig2_q, dig1_q};
    assign io.uio_oe  = 8'hFF;
    assign unused_ok  = ^{io.ena, io.uio_in};
endmodule

// File: tb/tb_seg7_digit_reader.sv
// tb_seg7_digit_reader: scoreboard bench; each expected digit is queued when its
// pattern is driven and checked when the reader pulses.
module tb_seg7_digit_reader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    seg7_digit_reader_if dif();
    seg7_digit_reader dut (.clk(clk), .rst_n(rst_n), .io(dif));
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] uo;
        logic [7:0] uio;
    } exp_t;
    exp_t sb[$];
    int n_tests = 0;
    int n_fail = 0;
    logic [3:0] m_d0, m_d1, m_d2;
    logic [1:0] m_cnt;
    logic m_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] m_uo(input logic pulse);
        return {m_cnt, m_err, pulse, m_d0};
    endfunction

    task automatic push_digit(input logic [3:0] n);
        m_d2 = m_d1;
        m_d1 = m_d0;
        m_d0 = n;
        m_cnt = m_cnt + 2'd1;
        sb.push_back('{m_uo(1'b1), {m_d2, m_d1}});
    endtask

    task automatic hold(input logic e, input logic [6:0] pat, input int n);
        dif.ui_in = {e, pat};
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        dif.ui_in = 8'h00;
        {m_d0, m_d1, m_d2, m_cnt, m_err} = '0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && dif.uo_out[4]) begin
            if (sb.size() == 0)
                chk("unexpected_pulse", dif.uo_out, 8'h00);
            else begin
                e = sb.pop_front();
                chk("pulse_uo", dif.uo_out, e.uo);
                chk("pulse_uio", dif.uio_out, e.uio);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [6:0] pats [9];
        pats = '{7'h3F, 7'h00, 7'h3F, 7'h00, 7'h3F, 7'h00, 7'h3F, 7'h00, 7'h3F};
        dif.ena = 1'b1;
        dif.uio_in = 8'h00;
        dif.ui_in = 8'h00;
        do_reset();
        chk("rst_uo", dif.uo_out, 8'h00);
        chk("rst_uio", dif.uio_out, 8'h00);
        chk("rst_oe", dif.uio_oe, 8'hFF);

        dif.ui_in = 8'h86;
        push_digit(4'h1);
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk);
            #1;
            chk(k < 7 ? "lat_wait" : "lat_pulse", dif.uo_out, k < 7 ? 8'h00 : 8'h51);
        end
        @(posedge clk);
        #1 chk("lat_after", dif.uo_out, 8'h41);
        hold(1'b1, 7'h06, 5);

        do_reset();
        for (int i = 0; i < 9; i++) begin
            if (pats[i] != 7'h00) push_digit(4'h0);
            hold(1'b1, pats[i], 10);
        end
        chk("wrap_uo", dif.uo_out, 8'h40);
        chk("wrap_uio", dif.uio_out, 8'h00);

        push_digit(4'h2); hold(1'b1, 7'h5B, 10);
        push_digit(4'h3); hold(1'b1, 7'h4F, 10);
        push_digit(4'h4); hold(1'b1, 7'h66, 10);
        chk("hist_digit", dif.uo_out[3:0], 4'h4);
        chk("hist_uio", dif.uio_out, 8'h23);
        chk("hist_uo", dif.uo_out, m_uo(1'b0));

        push_digit(4'h5); hold(1'b1, 7'h6D, 10);
        hold(1'b1, 7'h7D, 2);
        hold(1'b1, 7'h6D, 10);
        chk("glitch_uo", dif.uo_out, m_uo(1'b0));
        push_digit(4'h6); hold(1'b1, 7'h7D, 6);
        push_digit(4'h5); hold(1'b1, 7'h6D, 10);
        chk("excursion_uo", dif.uo_out, m_uo(1'b0));
        chk("excursion_uio", dif.uio_out, {m_d2, m_d1});

        hold(1'b1, 7'h7E, 10);
        chk("err_set", dif.uo_out[5], 1'b1);
        m_err = 1'b1;
        chk("err_nopulse", dif.uo_out, m_uo(1'b0));
        push_digit(4'h7); hold(1'b1, 7'h07, 10);
        chk("err_sticky", dif.uo_out, m_uo(1'b0));

        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_uo", dif.uo_out, 8'h00);
        chk("arst_uio", dif.uio_out, 8'h00);
        chk("arst_oe", dif.uio_oe, 8'hFF);
        do_reset();

        push_digit(4'hC); hold(1'b1, 7'h39, 10);
        for (int i = 0; i < 5; i++) begin
            hold(1'b0, (i % 2 == 0) ? 7'h77 : 7'h00, 10);
            chk("en_hold", dif.uo_out, m_uo(1'b0));
        end
        dif.ui_in = 8'hF7;
        push_digit(4'hA);
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk);
            #1;
            chk(k < 7 ? "en_wait" : "en_pulse", dif.uo_out[4], k < 7 ? 1'b0 : 1'b1);
        end
        hold(1'b1, 7'h77, 5);
        chk("en_final", dif.uo_out, m_uo(1'b0));
        chk("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
